// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling with 3-sample majority vote,
// false-start rejection, break detection and a show-ahead receive FIFO with
// valid/ready handshake and sticky overrun flag.
module uart_rx_param #(
  parameter int unsigned CLK_RATE   = 100000000,
  parameter int unsigned BAUD_RATE  = 19200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clear_overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int unsigned DIV     = CLK_RATE / (16 * BAUD_RATE);
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = DATA_BITS + 2;

  typedef enum logic [2:0] {
    StWaitHigh,
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e state_q, state_d;

  logic               rx_meta_q, rx_s_q;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]         samp_cnt_q, samp_cnt_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic               par_q, par_d;
  logic               s7_q, s8_q;
  logic               break_q;

  logic counting, tick, decide, bit_end, maj;
  logic is_break, push, brk_hit, calc_par_err;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign counting = (state_q == StStart) || (state_q == StData) ||
                    (state_q == StParity) || (state_q == StStop);
  assign tick     = counting && (div_cnt_q == DIV_W'(DIV - 1));
  assign decide   = tick && (samp_cnt_q == 4'd9);
  assign bit_end  = tick && (samp_cnt_q == 4'd15);
  assign maj      = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);

  // Divider and sample counter restart while idle, so the first tick lands
  // DIV cycles after start detection
  always_comb begin
    div_cnt_d  = div_cnt_q;
    samp_cnt_d = samp_cnt_q;
    if (!counting) begin
      div_cnt_d  = '0;
      samp_cnt_d = '0;
    end else if (tick) begin
      div_cnt_d  = '0;
      samp_cnt_d = samp_cnt_q + 4'd1;
    end else begin
      div_cnt_d  = div_cnt_q + DIV_W'(1);
    end
  end

  // Break: all-zero data, zero parity sample (if any) and zero stop bit
  always_comb begin
    is_break = (data_q == '0) && !maj;
    if (PARITY != 0) is_break = is_break && !par_q;
  end

  // Parity check of the assembled frame
  always_comb begin
    calc_par_err = 1'b0;
    if (PARITY == 1) calc_par_err = ((^data_q) ^ par_q) == 1'b0;
    if (PARITY == 2) calc_par_err = ((^data_q) ^ par_q) == 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StWaitHigh;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitHigh: if (rx_s_q) state_d = StIdle;
      StIdle:     if (!rx_s_q) state_d = StStart;
      StStart: begin
        if (decide && maj)  state_d = StIdle;
        else if (bit_end)   state_d = StData;
      end
      StData: begin
        if (bit_end && (bit_cnt_q == 4'(DATA_BITS - 1))) begin
          state_d = (PARITY != 0) ? StParity : StStop;
        end
      end
      StParity: if (bit_end) state_d = StStop;
      // Leave at mid-stop-bit to gain half a bit of resync margin
      StStop: if (decide) state_d = is_break ? StWaitHigh : StIdle;
      default: state_d = StWaitHigh;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy    = (state_q != StIdle);
    push    = (state_q == StStop) && decide && !is_break;
    brk_hit = (state_q == StStop) && decide && is_break;
  end

  // Frame datapath next state: bit counter, LSB-first shifter, parity sample
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_d     = par_q;
    if (state_q == StStart) begin
      bit_cnt_d = '0;
      data_d    = '0;
      par_d     = 1'b0;
    end
    if (state_q == StData) begin
      if (decide)  data_d = {maj, data_q[DATA_BITS-1:1]};
      if (bit_end) bit_cnt_d = bit_cnt_q + 4'd1;
    end
    if ((state_q == StParity) && decide) par_d = maj;
  end

  // Frame datapath registers and majority-vote samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
      break_q    <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_q      <= par_d;
      if (tick && (samp_cnt_q == 4'd7)) s7_q <= rx_s_q;
      if (tick && (samp_cnt_q == 4'd8)) s8_q <= rx_s_q;
      break_q    <= brk_hit;
    end
  end

  assign break_det = break_q;

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overrun_q;
  logic               full, pop, wr_en, drop;
  logic [ENTRY_W-1:0] head;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop   = dout_valid && dout_ready;
  // When full, a simultaneous pop frees the head slot, which is exactly wr_ptr
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign head  = mem_q[rd_ptr_q];

  // FIFO occupancy next state
  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
  end

  // FIFO storage, pointers and sticky overrun (set wins over clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {data_q, calc_par_err, ~maj};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (drop)               overrun_q <= 1'b1;
      else if (clear_overrun) overrun_q <= 1'b0;
    end
  end

  // Show-ahead head outputs, forced to zero while empty
  always_comb begin
    dout_valid = (count_q != '0);
    dout       = '0;
    parity_err = 1'b0;
    frame_err  = 1'b0;
    if (dout_valid) begin
      dout       = head[ENTRY_W-1:2];
      parity_err = head[1];
      frame_err  = head[0];
    end
    overrun = overrun_q;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the I/O system: the next generation of the fixed 8-bit receiver. Adds configurable data width and parity mode, 16x oversampling with 3-sample majority vote, false-start rejection, break detection, and a show-ahead receive FIFO with valid/ready handshake and overrun flag. Sits between the board RX pin and the memory-mapped UART register block.

## Interface
- CLK_RATE, 100000000, clock frequency in Hz
- BAUD_RATE, 19200, bit rate; CLK_RATE >= 16*BAUD_RATE required
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- FIFO_DEPTH, 4, receive FIFO entries, power of two >= 2

- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- rx_in  in  1  serial input, asynchronous to clk, idle high
- dout  out  DATA_BITS  FIFO head data
- dout_valid  out  1  FIFO not empty
- dout_ready  in  1  consumer pops head when dout_valid & dout_ready
- parity_err  out  1  parity error of head entry (0 when PARITY=0)
- frame_err  out  1  stop-bit error of head entry
- overrun  out  1  sticky: frame dropped because FIFO full
- clear_overrun  in  1  clears overrun
- break_det  out  1  one-cycle pulse on break
- busy  out  1  receiver not in IDLE

## Operation
- rx_in passes through 2-FF synchroniser (reset value 1); all logic uses synchronised rx_s.
- Tick generator: DIV = CLK_RATE/(16*BAUD_RATE); tick every DIV cycles; divider reloaded on IDLE->START so first tick is DIV cycles after detection. 4-bit sample counter advances per tick; 16 ticks per bit.
- Each bit: samples at ticks 7, 8, 9; bit value = majority, decided at tick 9.
- States:
  - WAIT_HIGH (reset state): busy=1; -> IDLE when rx_s=1.
  - IDLE: busy=0; -> START when rx_s=0.
  - START: majority 1 -> IDLE (false start, nothing pushed); else at tick 15 -> DATA.
  - DATA: DATA_BITS bits LSB first; after last -> PARITY if PARITY!=0, else STOP.
  - PARITY: sample parity bit; odd: error if ^data ^ p == 0; even: error if ^data ^ p == 1.
  - STOP: at tick 9 decide. If data all 0, parity sample 0 (or none) and stop 0: break -> pulse break_det, no push, -> WAIT_HIGH. Otherwise push {data, parity_err, frame_err = ~stop} and -> IDLE same cycle (half-stop-bit resync margin).
- FIFO: show-ahead, entries DATA_BITS+2 wide. Push when not full, or full with simultaneous pop (count unchanged). Push while full without pop: frame dropped, overrun set.
- overrun: set has priority over clear_overrun in same cycle.

## Timing
- Reset values: dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, break_det=0, busy=1 (WAIT_HIGH); FIFO empty, counters 0.
- rst_n assertion mid-frame aborts immediately; partial frame discarded; after release, rx_s must be seen high before a start is accepted.
- rx_in edge -> rx_s: 2 cycles. Start detect -> START: 1 cycle after rx_s low.
- Push occurs at stop-bit tick 9; dout_valid rises the following cycle.
- Pop: head advances the cycle after dout_valid & dout_ready; dout_ready ignored when empty.
- break_det exactly 1 cycle; busy falls when IDLE entered.

## Test plan
Bench uses CLK_RATE=1600000, BAUD_RATE=100000 (DIV=1, 16 cycles/bit), DATA_BITS=8, PARITY=1, FIFO_DEPTH=4.
- Send 0xA5, parity 1, stop 1 -> dout=0xA5, dout_valid=1, parity_err=0, frame_err=0; dout_ready pulse -> dout_valid=0.
- Send 0xA5, parity 0 -> parity_err=1, frame_err=0; send 0x3C, parity 1, stop 0 -> frame_err=1, parity_err=0.
- rx_in low 5 cycles then high -> busy high then low, no push, dout_valid stays 0.
- dout_ready=0, send 0x01..0x05 -> 0x01..0x04 held, overrun=1, 0x05 lost; pop 4 -> 0x01..0x04 in order; clear_overrun -> overrun=0.
- Hold rx_in low 200 cycles -> single break_det pulse, no push, busy=1 until rx_in high, then IDLE.
- Assert rst_n during DATA bit 3 -> all outputs at reset values; release with rx_in high, send 0x5A -> received correctly.
